icb_bias_sram_slave: RTL and testbench

- ICB-ext slave (responder) fronting a local word-addressed SRAM that holds bias vectors.
- Serves single-beat and burst read commands issued by the bias-loading masters.
- Accepts burst writes from the host/DMA side that fills the bias table.
- Handles one outstanding command at a time; provides the cmd/wr/rsp handshakes that the loader-side master expects.

---
 rtl/icb_bias_sram_slave_if.sv | 42 ++++
 rtl/icb_bias_sram_slave.sv | 202 ++++++++++++++++++++
 tb/tb_icb_bias_sram_slave.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icb_bias_sram_slave_if.sv
// ICB-ext bus bundle between a bias-loading master and icb_bias_sram_slave.
// Parameters must match those of the slave instance the bundle is attached to.
interface icb_bias_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 3
);
    // Handshakes (cmd, w, rsp): a beat transfers on a rising clk edge where
    // valid && ready. Once raised, valid and its payload stay stable until that
    // edge. ready may depend combinationally on state but never on valid.
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic                      cmd_read;
    logic [LEN_WIDTH-1:0]      cmd_len;

    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wmask;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_len,
        input  w_valid, wdata, wmask,
        input  rsp_ready,
        output cmd_ready, w_ready,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_len,
        output w_valid, wdata, wmask,
        output rsp_ready,
        input  cmd_ready, w_ready,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/icb_bias_sram_slave.sv
// ICB-ext slave serving burst reads/writes of a word-addressed bias SRAM, one command at a time.
// Define ICB_BIAS_SRAM_RANGE_CHK_EN to flag misaligned / out-of-range bursts with rsp_err.
module icb_bias_sram_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int                    LEN_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    icb_bias_sram_slave_if.slave  bus,
    output logic                  busy,
    output logic [1:0]            state_dbg
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int MASK_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_WRSP = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic                   mem_we;
    logic [IDX_W-1:0]       mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [MASK_W-1:0]      mem_wbe;
    logic [IDX_W-1:0]       mem_raddr;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    logic                   cmd_ready_c;
    logic                   w_ready_c;

    // Command decode: word index relative to BASE_ADDR and the error verdict.
    logic [ADDR_WIDTH-1:0]  cmd_off;
    logic [IDX_W-1:0]       cmd_idx;
    logic                   cmd_err;
    logic                   unused_off;

    assign cmd_off = bus.cmd_addr - BASE_ADDR;
    assign cmd_idx = cmd_off[IDX_W+1:2];

`ifdef ICB_BIAS_SRAM_RANGE_CHK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
    logic [ADDR_WIDTH:0] cmd_last_word;

    // Whole burst must fit below DEPTH; no wrap-around allowed.
    assign cmd_last_word = {3'b000, cmd_off[ADDR_WIDTH-1:2]}
                         + {{(ADDR_WIDTH+1-LEN_WIDTH){1'b0}}, bus.cmd_len};
    assign cmd_err       = (bus.cmd_addr[1:0] != 2'b00)
                         || (bus.cmd_addr < BASE_ADDR)
                         || (cmd_last_word >= DEPTH_LIM);
    assign unused_off    = ^cmd_off[1:0];
`else
    assign cmd_err       = 1'b0;
    assign unused_off    = ^{cmd_off[1:0], cmd_off[ADDR_WIDTH-1:IDX_W+2]};
`endif

    // Single read port: IDLE reads at the incoming index so beat 0 is ready at T+1.
    assign mem_raddr = (state_q == S_IDLE) ? cmd_idx : idx_q;
    assign mem_rdata = mem_q[mem_raddr];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        mem_waddr   = idx_q;
        mem_wdata   = bus.wdata;
        mem_wbe     = bus.wmask;
        cmd_ready_c = 1'b0;
        w_ready_c   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    err_d = cmd_err;
                    cnt_d = bus.cmd_len;
                    if (bus.cmd_read) begin
                        state_d     = S_RD;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = cmd_err ? '0 : mem_rdata;
                        rsp_err_d   = cmd_err;
                        idx_d       = cmd_idx + IDX_W'(1);
                    end else begin
                        state_d = S_WR;
                        idx_d   = cmd_idx;
                    end
                end
            end

            // cnt_q counts beats still to be loaded into the response register.
            S_RD: begin
                if (rsp_valid_q && bus.rsp_ready && (cnt_q == '0)) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end else if ((!rsp_valid_q || bus.rsp_ready) && (cnt_q != '0)) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = err_q ? '0 : mem_rdata;
                    rsp_err_d   = err_q;
                    idx_d       = idx_q + IDX_W'(1);
                    cnt_d       = cnt_q - LEN_WIDTH'(1);
                end
            end

            // cnt_q counts write beats remaining after the current one.
            S_WR: begin
                w_ready_c = 1'b1;
                if (bus.w_valid) begin
                    mem_we = !err_q;
                    idx_d  = idx_q + IDX_W'(1);
                    if (cnt_q == '0) begin
                        state_d     = S_WRSP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = err_q;
                    end else begin
                        cnt_d = cnt_q - LEN_WIDTH'(1);
                    end
                end
            end

            S_WRSP: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // SRAM array: contents intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (mem_wbe[b]) begin
                    mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // cmd_ready is gated by rst_n so it reads 0 while reset is held.
    assign bus.cmd_ready = cmd_ready_c & rst_n;
    assign bus.w_ready   = w_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != S_IDLE);
    assign state_dbg     = state_q;

    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid && !bus.rsp_ready) |=>
        (bus.rsp_valid && $stable(bus.rsp_rdata) && $stable(bus.rsp_err)));

    a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
        bus.cmd_ready |-> !busy);
endmodule

// File: tb/tb_icb_bias_sram_slave.sv
// Self-checking bench for icb_bias_sram_slave: random bursts against a word-array reference
// model, expected responses queued at command acceptance and checked by a response monitor.
module tb_icb_bias_sram_slave;
    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 256;
    localparam int          LW    = 3;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [1:0] state_dbg;

    icb_bias_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    icb_bias_sram_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LEN_WIDTH(LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] exp_q[$];      // {err, rdata}
    int          exp_cyc_q[$];  // expected handshake cycle, -1 = not timed
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wbuf [8];
    logic [3:0]  mbuf [8];
    bit          rand_ready = 0;
    bit          pat_q[$];
    int          last_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t cyc=%0d)", name, act, exp_v, $time, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_err(input logic [31:0] addr, input int len);
`ifdef ICB_BIAS_SRAM_RANGE_CHK_EN
        if (addr[1:0] != 2'b00) return 1'b1;
        if (addr < BASE) return 1'b1;
        return (64'((addr - BASE) >> 2) + 64'(len)) >= 64'(DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] apply_mask(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ---------------- rsp_ready driver ----------------
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid && pat_q.size() != 0) bus.rsp_ready = pat_q.pop_front();
            else if (rand_ready) bus.rsp_ready = ($urandom_range(0, 2) != 0);
            else bus.rsp_ready = 1'b1;
        end
    end

    // ---------------- response monitor ----------------
    bit          prev_stall = 0;
    logic [32:0] prev_rsp;
    always @(negedge clk) begin
        logic [32:0] e;
        int          c;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("rsp_hold_valid", bus.rsp_valid, 1);
                chk("rsp_hold_data", {bus.rsp_err, bus.rsp_rdata}, prev_rsp);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rsp_unexpected: got err=%0b rdata=0x%0h expected no response",
                             bus.rsp_err, bus.rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    chk("rsp_beat", {bus.rsp_err, bus.rsp_rdata}, e);
                    if (c >= 0) chk("rsp_cycle", cyc, c);
                end
            end
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev_rsp   = {bus.rsp_err, bus.rsp_rdata};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done();
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #2;
            guard++;
        end while ((exp_q.size() != 0 || busy) && guard < 500);
        chk("burst_done", (exp_q.size() == 0 && !busy), 1);
        chk("cmd_ready_after", bus.cmd_ready, 1);
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic issue(input logic [31:0] addr, input bit rd, input int len, input bit wait_end);
        bit err;
        bit timed;
        int idx;
        int guard;
        err = model_err(addr, len);
        idx = int'(((addr - BASE) >> 2) % DEPTH);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_read  = rd;
        bus.cmd_len   = LW'(len);
        guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_accept", bus.cmd_ready, 1);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        timed = !rand_ready && (pat_q.size() == 0);
        if (rd) begin
            for (int i = 0; i <= len; i++) begin
                exp_q.push_back({err, err ? 32'h0 : ref_mem[(idx + i) % DEPTH]});
                exp_cyc_q.push_back(timed ? last_acc + 1 + i : -1);
            end
        end else begin
            if (!err)
                for (int i = 0; i <= len; i++)
                    ref_mem[(idx + i) % DEPTH] = apply_mask(ref_mem[(idx + i) % DEPTH], wbuf[i], mbuf[i]);
            exp_q.push_back({err, 32'h0});
            exp_cyc_q.push_back(timed ? last_acc + len + 2 : -1);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (!rd) begin
            for (int b = 0; b <= len; b++) begin
                bus.w_valid = 1'b1;
                bus.wdata   = wbuf[b];
                bus.wmask   = mbuf[b];
                guard = 0;
                @(negedge clk);
                while (!bus.w_ready && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                chk("w_beat_cycle", cyc, last_acc + 1 + b);
                @(posedge clk);
                #1;
            end
            bus.w_valid = 1'b0;
        end
        if (wait_end) wait_done();
    endtask

    task automatic fill_bufs(input bit full_mask);
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = $urandom;
            mbuf[i] = full_mask ? 4'hF : 4'($urandom_range(0, 15));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] addr;
        int          r;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_read  = 1'b0;
        bus.cmd_len   = '0;
        bus.w_valid   = 1'b0;
        bus.wdata     = '0;
        bus.wmask     = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_w_ready", bus.w_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        // Preload the whole SRAM so every model word is known.
        for (int blk = 0; blk < DEPTH / 8; blk++) begin
            fill_bufs(1);
            issue(BASE + 32'(32 * blk), 1'b0, 7, 1'b1);
        end

        // Directed 4-beat write then read-back at BASE+0x10.
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        for (int i = 0; i < 4; i++) mbuf[i] = 4'hF;
        issue(BASE + 32'h10, 1'b0, 3, 1'b1);
        issue(BASE + 32'h10, 1'b1, 3, 1'b1);

        // Read with a stalling rsp_ready pattern.
        pat_q = '{1, 0, 0, 1, 1, 0, 1};
        issue(BASE + 32'h10, 1'b1, 3, 1'b1);
        pat_q.delete();

        // Partial byte-mask write over an all-ones word.
        wbuf[0] = 32'hFFFF_FFFF; mbuf[0] = 4'hF;
        issue(BASE + 32'h20, 1'b0, 0, 1'b1);
        wbuf[0] = 32'hAABB_CCDD; mbuf[0] = 4'b0101;
        issue(BASE + 32'h20, 1'b0, 0, 1'b1);
        issue(BASE + 32'h20, 1'b1, 0, 1'b1);

        // Burst crossing the top of the SRAM, then misaligned write and read-back of word 0.
        issue(BASE + 32'(4 * (DEPTH - 2)), 1'b1, 3, 1'b1);
        wbuf[0] = 32'h1234_5678; mbuf[0] = 4'hF;
        issue(BASE + 32'h2, 1'b0, 0, 1'b1);
        issue(BASE, 1'b1, 1, 1'b1);

        // Randomized traffic with random rsp_ready back-pressure.
        rand_ready = 1;
        for (int n = 0; n < 60; n++) begin
            fill_bufs(0);
            addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            r = $urandom_range(0, 9);
            if (r == 0) addr = addr + 32'($urandom_range(1, 3));
            if (r == 1) addr = BASE - 32'd4;
            issue(addr, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'b1);
        end
        rand_ready = 0;

        // Reset asserted while beat 2 of a 6-beat read is on the bus.
        issue(BASE + 32'h40, 1'b1, 5, 1'b0);
        while (cyc < last_acc + 3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_no_rsp", bus.rsp_valid, 0);
        issue(BASE + 32'h40, 1'b1, 5, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
